uart_wb_hub: RTL and testbench

- Parametrised Wishbone classic fan-out hub for N UART channels.
- Connects one upstream master (the testbench driver or the CPU port) to `N_CH` downstream UART Wishbone slaves, decoding on the high address bits.
- Registers every transfer through a small FSM with optional timeout.
- Aggregates masked per-channel interrupts onto a single `INT_O`.
- Sits between the system bus and the UART cores. It replaces the current one-channel, 8-bit-only hookup.

---
 rtl/uart_wb_hub_pkg.sv | 14 +
 rtl/uart_wb_hub_intc.sv | 40 ++++
 rtl/uart_wb_hub.sv | 152 +++++++++++++++
 tb/tb_uart_wb_hub.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_hub_pkg.sv
// Shared types and constants for the UART Wishbone hub: FSM state encoding
// and the offsets of the hub-local registers.
package uart_wb_hub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP
    } hub_state_e;

    localparam int HUB_INT_PEND = 0;
    localparam int HUB_INT_MASK = 1;

endpackage

// File: rtl/uart_wb_hub_intc.sv
// Interrupt aggregation for the hub: byte-lane writable INT_MASK (resets to all
// ones), combinational pending vector and a registered OR onto int_o.
module uart_wb_hub_intc #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              mask_wr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [N_CH-1:0]   ch_int_i,
    output logic [N_CH-1:0]   int_mask,
    output logic [N_CH-1:0]   int_pend,
    output logic              int_o
);

    // Mask bits beyond the data bus cannot be addressed, so they stay enabled.
    for (genvar i = 0; i < N_CH; i++) begin : g_mask
        if (i < DATA_W) begin : g_wr
            always_ff @(posedge clock) begin
                if (rst)
                    int_mask[i] <= 1'b1;
                else if (mask_wr && wr_sel[i/8])
                    int_mask[i] <= wr_dat[i];
            end
        end else begin : g_ro
            always_ff @(posedge clock) int_mask[i] <= 1'b1;
        end
    end

    assign int_pend = ch_int_i & int_mask;

    always_ff @(posedge clock) begin
        if (rst) int_o <= 1'b0;
        else     int_o <= |int_pend;
    end

endmodule

// File: rtl/uart_wb_hub.sv
// uart_wb_hub: Wishbone classic fan-out from one master to N_CH UART slaves plus
// hub-local IRQ registers. Build macro UART_WB_HUB_TIMEOUT_EN adds the ack timeout.
module uart_wb_hub
    import uart_wb_hub_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = DATA_W / 8,
    localparam int CH_W   = $clog2(N_CH + 1)
) (
    input  logic                     clock,
    input  logic                     WB_RST_I,
    input  logic [CH_W+ADDR_W-1:0]   WB_ADDR_I,
    input  logic [DATA_W-1:0]        WB_DAT_I,
    input  logic [SEL_W-1:0]         WB_SEL_I,
    input  logic                     WB_WE_I,
    input  logic                     WB_STB_I,
    input  logic                     WB_CYC_I,
    output logic [DATA_W-1:0]        WB_DAT_O,
    output logic                     WB_ACK_O,
    output logic                     WB_ERR_O,
    output logic                     INT_O,
    output logic [ADDR_W-1:0]        ch_adr_o,
    output logic [DATA_W-1:0]        ch_dat_o,
    output logic [SEL_W-1:0]         ch_sel_o,
    output logic                     ch_we_o,
    output logic [N_CH-1:0]          ch_cyc_o,
    output logic [N_CH-1:0]          ch_stb_o,
    input  logic [N_CH*DATA_W-1:0]   ch_dat_i,
    input  logic [N_CH-1:0]          ch_ack_i,
    input  logic [N_CH-1:0]          ch_int_i
);

    localparam logic [CH_W-1:0] HUB_SEL = CH_W'(N_CH);
    localparam int              RD_W    = (N_CH < DATA_W) ? N_CH : DATA_W;

    hub_state_e        state, state_n;
    logic [CH_W-1:0]   ch_q, req_ch;
    logic [ADDR_W-1:0] adr_q, req_off;
    logic [DATA_W-1:0] dat_q, rdata_q, ch_rd, local_rd;
    logic [SEL_W-1:0]  sel_q;
    logic              we_q, err_q;
    logic [N_CH-1:0]   ch_oh, int_mask, int_pend;
    logic              req, ack_hit, tmo, mask_wr;

    assign req               = WB_CYC_I & WB_STB_I;
    assign {req_ch, req_off} = WB_ADDR_I;
    assign ch_oh             = N_CH'(1) << ch_q;
    assign ack_hit           = |(ch_ack_i & ch_oh);
    assign mask_wr           = (state == IDLE) && req && (req_ch == HUB_SEL) && WB_WE_I
                               && (req_off == ADDR_W'(HUB_INT_MASK));

    always_comb begin
        ch_rd = '0;
        for (int k = 0; k < N_CH; k++)
            if (ch_q == CH_W'(k)) ch_rd = ch_dat_i[k*DATA_W +: DATA_W];
    end

    always_comb begin
        local_rd = '0;
        if (req_off == ADDR_W'(HUB_INT_PEND))      local_rd[RD_W-1:0] = int_pend[RD_W-1:0];
        else if (req_off == ADDR_W'(HUB_INT_MASK)) local_rd[RD_W-1:0] = int_mask[RD_W-1:0];
    end

`ifdef UART_WB_HUB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    always_ff @(posedge clock) begin
        if (WB_RST_I || state != FWD) tmo_cnt <= '0;
        else                          tmo_cnt <= tmo_cnt + 16'd1;
    end
    // Expiry is sampled on the last counted cycle so ERR lands in cycle TIMEOUT+1.
    assign tmo = (tmo_cnt == 16'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (WB_RST_I) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = (req_ch < HUB_SEL) ? FWD : RESP;
            FWD:     if (!WB_CYC_I) state_n = IDLE;
                     else if (ack_hit || tmo) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (WB_RST_I) begin
            ch_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    ch_q    <= req_ch;
                    adr_q   <= req_off;
                    dat_q   <= WB_DAT_I;
                    sel_q   <= WB_SEL_I;
                    we_q    <= WB_WE_I;
                    err_q   <= (req_ch > HUB_SEL);
                    rdata_q <= local_rd;
                end
                // An ack coinciding with expiry wins over the timeout.
                FWD: if (ack_hit) begin
                    rdata_q <= ch_rd;
                    err_q   <= 1'b0;
                end else if (tmo) begin
                    err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ch_cyc_o = (state == FWD) ? ch_oh : '0;
    assign ch_stb_o = (state == FWD) ? ch_oh : '0;
    assign ch_adr_o = adr_q;
    assign ch_dat_o = dat_q;
    assign ch_sel_o = sel_q;
    assign ch_we_o  = we_q;
    assign WB_ACK_O = (state == RESP) && !err_q;
    assign WB_ERR_O = (state == RESP) && err_q;
    assign WB_DAT_O = WB_ACK_O ? rdata_q : '0;

    uart_wb_hub_intc #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) u_intc (
        .clock    (clock),
        .rst      (WB_RST_I),
        .mask_wr  (mask_wr),
        .wr_dat   (WB_DAT_I),
        .wr_sel   (WB_SEL_I),
        .ch_int_i (ch_int_i),
        .int_mask (int_mask),
        .int_pend (int_pend),
        .int_o    (INT_O)
    );

endmodule

// File: tb/tb_uart_wb_hub.sv
// Directed plus randomized bench for uart_wb_hub (N_CH=4, DATA_W=8, ADDR_W=3, TIMEOUT=8)
// against a transaction-level model of decode, latency and interrupt masking.
module tb_uart_wb_hub;

    localparam int TIMEOUT = 8;

    logic        clock = 1'b0;
    logic        WB_RST_I;
    logic [5:0]  WB_ADDR_I;
    logic [7:0]  WB_DAT_I;
    logic [0:0]  WB_SEL_I;
    logic        WB_WE_I, WB_STB_I, WB_CYC_I;
    logic [7:0]  WB_DAT_O;
    logic        WB_ACK_O, WB_ERR_O, INT_O;
    logic [2:0]  ch_adr_o;
    logic [7:0]  ch_dat_o;
    logic [0:0]  ch_sel_o;
    logic        ch_we_o;
    logic [3:0]  ch_cyc_o, ch_stb_o;
    logic [31:0] ch_dat_i;
    logic [3:0]  ch_ack_i, ch_int_i;

    always #5 clock = ~clock;

    uart_wb_hub #(.N_CH(4), .DATA_W(8), .ADDR_W(3), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .WB_RST_I(WB_RST_I), .WB_ADDR_I(WB_ADDR_I), .WB_DAT_I(WB_DAT_I),
        .WB_SEL_I(WB_SEL_I), .WB_WE_I(WB_WE_I), .WB_STB_I(WB_STB_I), .WB_CYC_I(WB_CYC_I),
        .WB_DAT_O(WB_DAT_O), .WB_ACK_O(WB_ACK_O), .WB_ERR_O(WB_ERR_O), .INT_O(INT_O),
        .ch_adr_o(ch_adr_o), .ch_dat_o(ch_dat_o), .ch_sel_o(ch_sel_o), .ch_we_o(ch_we_o),
        .ch_cyc_o(ch_cyc_o), .ch_stb_o(ch_stb_o), .ch_dat_i(ch_dat_i), .ch_ack_i(ch_ack_i),
        .ch_int_i(ch_int_i)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] mask_m = 4'hF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_int(input string tag, input logic [3:0] v);
        logic [3:0] old;
        old = ch_int_i;
        ch_int_i = v;
        #1;
        chk({tag, "_int_lag"}, INT_O, |(old & mask_m));
        step();
        chk({tag, "_int_new"}, INT_O, |(v & mask_m));
    endtask

    // Cycle 0 is the cycle in which the request is first sampled.
    task automatic xfer(input string tag, input logic [5:0] adr, input logic [7:0] dat,
                        input logic sel, input logic we, input int w, input logic [7:0] sdat,
                        input bit silent, input int abort_at, input bit rst_abort);
        logic [2:0] s, off, s_adr;
        logic [7:0] s_dat, rd, exp_rd;
        logic [3:0] stb_or, exp_stb, mask_next, stb_after, stb_resp;
        logic       s_we;
        int         si, exp_ack, exp_err, ack_c, err_c, n_ack, n_err, resp_c;
        bit         done;
        s = adr[5:3]; off = adr[2:0]; si = int'(s);
        exp_ack = 0; exp_err = 0; exp_rd = 0; exp_stb = 0; mask_next = mask_m;
        ack_c = 0; err_c = 0; n_ack = 0; n_err = 0; resp_c = 0; done = 0;
        stb_or = 0; stb_after = 0; stb_resp = 0; rd = 0; s_adr = 0; s_dat = 0; s_we = 0;

        if (si < 4) begin
            exp_stb = 4'(1) << si;
            if (silent) exp_err = TIMEOUT + 1;
            else begin exp_ack = 2 + w; exp_rd = sdat; end
        end else if (si == 4) begin
            exp_ack = 1;
            if (off == 3'd0)      exp_rd = {4'h0, ch_int_i & mask_m};
            else if (off == 3'd1) exp_rd = {4'h0, mask_m};
            if (we && sel && off == 3'd1) mask_next = dat[3:0];
        end else begin
            exp_err = 1;
        end

        WB_ADDR_I = adr; WB_DAT_I = dat; WB_SEL_I = sel; WB_WE_I = we;
        WB_CYC_I = 1'b1; WB_STB_I = 1'b1;
        for (int c = 1; c <= 40 && !done; c++) begin
            step();
            stb_or |= ch_stb_o;
            if (c == 1) begin s_adr = ch_adr_o; s_dat = ch_dat_o; s_we = ch_we_o; end
            if (c == abort_at + 1) stb_after = ch_stb_o;
            if (WB_ACK_O) begin n_ack++; if (ack_c == 0) begin ack_c = c; rd = WB_DAT_O; end end
            if (WB_ERR_O) begin n_err++; if (err_c == 0) err_c = c; end
            if ((WB_ACK_O || WB_ERR_O) && resp_c == 0) begin resp_c = c; stb_resp = ch_stb_o; end
            if (WB_ACK_O || WB_ERR_O) begin WB_CYC_I = 1'b0; WB_STB_I = 1'b0; end
            if (abort_at > 0 && c == abort_at) begin
                if (rst_abort) WB_RST_I = 1'b1;
                else begin WB_CYC_I = 1'b0; WB_STB_I = 1'b0; end
            end
            if (rst_abort && c == abort_at + 1) begin
                WB_RST_I = 1'b0; WB_CYC_I = 1'b0; WB_STB_I = 1'b0;
            end
            // Slave side: noise acks on other channels, the real ack after w wait states.
            ch_ack_i = 4'($urandom_range(0, 15));
            ch_dat_i = $urandom;
            if (si < 4) begin
                ch_ack_i[si] = !silent && abort_at == 0 && c == 1 + w;
                ch_dat_i[si*8 +: 8] = sdat;
            end
            if (resp_c > 0 && c >= resp_c + 1) done = 1;
            if (abort_at > 0 && c >= abort_at + 3) done = 1;
        end
        WB_CYC_I = 1'b0; WB_STB_I = 1'b0; WB_RST_I = 1'b0; ch_ack_i = '0;
        mask_m = rst_abort ? 4'hF : mask_next;

        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stb_seen"}, stb_or, exp_stb);
        if (abort_at > 0) begin
            chk({tag, "_no_resp"}, n_ack + n_err, 0);
            chk({tag, "_stb_drop"}, stb_after, 4'h0);
        end else begin
            if (exp_ack != 0) begin
                chk({tag, "_ack_cyc"}, ack_c, exp_ack);
                chk({tag, "_ack_cnt"}, {n_ack[15:0], n_err[15:0]}, {16'd1, 16'd0});
                if (!we) chk({tag, "_rdata"}, rd, exp_rd);
            end else begin
                chk({tag, "_err_cyc"}, err_c, exp_err);
                chk({tag, "_err_cnt"}, {n_ack[15:0], n_err[15:0]}, {16'd0, 16'd1});
            end
            chk({tag, "_stb_resp"}, stb_resp, 4'h0);
            if (si < 4) chk({tag, "_fwd"}, {s_adr, s_dat, s_we}, {off, dat, we});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        WB_RST_I = 1'b1; WB_ADDR_I = '0; WB_DAT_I = '0; WB_SEL_I = '0; WB_WE_I = 1'b0;
        WB_STB_I = 1'b0; WB_CYC_I = 1'b0; ch_dat_i = '0; ch_ack_i = '0; ch_int_i = '0;
        step(); step();
        chk("reset_outs", {WB_DAT_O, WB_ACK_O, WB_ERR_O, INT_O, ch_adr_o, ch_dat_o,
                           ch_sel_o, ch_we_o, ch_cyc_o, ch_stb_o}, '0);
        WB_RST_I = 1'b0;
        step();

        xfer("mask_rst", {3'd4, 3'd1}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
        xfer("wr_ch2", {3'd2, 3'd3}, 8'h5A, 1'b1, 1'b1, 1, 8'h11, 0, 0, 0);
        xfer("rd_ch0", {3'd0, 3'd5}, 8'h00, 1'b1, 1'b0, 0, 8'hC3, 0, 0, 0);
        xfer("dec_err", {3'd5, 3'd0}, 8'h77, 1'b1, 1'b1, 0, 8'h00, 0, 0, 0);
        xfer("dec_err7", {3'd7, 3'd2}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
        xfer("mask_wr", {3'd4, 3'd1}, 8'h02, 1'b1, 1'b1, 0, 8'h00, 0, 0, 0);
        set_int("irq", 4'b0011);
        xfer("pend_rd", {3'd4, 3'd0}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
        xfer("mask_nosel", {3'd4, 3'd1}, 8'h0F, 1'b0, 1'b1, 0, 8'h00, 0, 0, 0);
        xfer("mask_rd2", {3'd4, 3'd1}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
        xfer("local_oth", {3'd4, 3'd6}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
`ifdef UART_WB_HUB_TIMEOUT_EN
        xfer("tmo", {3'd1, 3'd2}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1, 0, 0);
        xfer("ack_at_tmo", {3'd3, 3'd4}, 8'h00, 1'b1, 1'b0, TIMEOUT - 1, 8'hE1, 0, 0, 0);
`else
        xfer("long_wait", {3'd3, 3'd4}, 8'h00, 1'b1, 1'b0, 10, 8'hE1, 0, 0, 0);
`endif
        xfer("cyc_abort", {3'd1, 3'd0}, 8'h3C, 1'b1, 1'b1, 0, 8'h00, 1, 3, 0);
        xfer("rst_abort", {3'd2, 3'd1}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1, 2, 1);
        xfer("mask_post", {3'd4, 3'd1}, 8'h00, 1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
        set_int("irq2", 4'b0100);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] rs, ro;
            rs = 3'($urandom_range(0, 7));
            ro = (rs == 3'd4) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            if (i % 4 == 0) set_int($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)));
            xfer($sformatf("rnd%0d", i), {rs, ro}, 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 8'($urandom), 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
